// File: rtl/imem_boot_loader_pkg.sv
// rtl/imem_boot_loader_pkg.sv - shared encodings and constants for the instruction-memory boot loader
package imem_boot_loader_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BEAT_W     = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEPT = 3'd1,
        ST_WRITE  = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_e;

endpackage

// File: rtl/imem_boot_loader_word_byte_select.sv
// rtl/imem_boot_loader_word_byte_select.sv - picks one byte of a word for a given write beat and byte order
module word_byte_select
    import imem_boot_loader_pkg::*;
(
    input  logic [31:0]       word,
    input  logic [BEAT_W-1:0] beat,
    input  logic              big_endian,
    output logic [7:0]        sel_byte
);

    logic [BEAT_W-1:0] lane;

    always_comb begin
        // Big-endian walks lanes 3..0 so beat 0 carries word[31:24].
        lane = big_endian ? ~beat : beat;
        case (lane)
            2'd0:    sel_byte = word[7:0];
            2'd1:    sel_byte = word[15:8];
            2'd2:    sel_byte = word[23:16];
            default: sel_byte = word[31:24];
        endcase
    end

endmodule

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - streams program words into byte-wide instruction memory and holds the CPU until done
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int BASE_ADDR  = 0,
    parameter int MAX_WORDS  = 128,
    parameter int BIG_ENDIAN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [31:0]       in_word,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_byte,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [7:0]        word_count
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [7:0]          word_count_q, word_count_d;
    logic [31:0]         word_q, word_d;
    logic                last_q, last_d;
    logic [7:0]          word_count_inc;
    logic [7:0]          beat_byte;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= ADDR_W'(BASE_ADDR);
            beat_q       <= '0;
            word_count_q <= '0;
            word_q       <= '0;
            last_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            beat_q       <= beat_d;
            word_count_q <= word_count_d;
            word_q       <= word_d;
            last_q       <= last_d;
        end
    end

    assign word_count_inc = word_count_q + 8'd1;

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        beat_d       = beat_q;
        word_count_d = word_count_q;
        word_d       = word_q;
        last_d       = last_q;
        case (state_q)
            ST_ACCEPT: begin
                if (in_valid) begin
                    word_d  = in_word;
                    last_d  = in_last;
                    beat_d  = '0;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                beat_d = beat_q + 1'b1;
                if (beat_q == BEAT_W'(WORD_BYTES - 1)) begin
                    ptr_d        = ptr_q + ADDR_W'(WORD_BYTES);
                    word_count_d = word_count_inc;
                    if (last_q) begin
                        state_d = ST_DONE;
                    end else if (word_count_inc == 8'(MAX_WORDS)) begin
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end
            end
            default: begin
                // IDLE, DONE and ERROR all (re)start a load the same way.
                if (start) begin
                    ptr_d        = ADDR_W'(BASE_ADDR);
                    word_count_d = '0;
                    state_d      = ST_ACCEPT;
                end
            end
        endcase
    end

    word_byte_select u_word_byte_select (
        .word       (word_q),
        .beat       (beat_q),
        .big_endian (BIG_ENDIAN != 0),
        .sel_byte   (beat_byte)
    );

    // Address and data are forced to zero outside WRITE so idle outputs read as 0.
    assign in_ready   = (state_q == ST_ACCEPT);
    assign mem_we     = (state_q == ST_WRITE);
    assign mem_addr   = mem_we ? (ptr_q + {{(ADDR_W-BEAT_W){1'b0}}, beat_q}) : '0;
    assign mem_byte   = mem_we ? beat_byte : 8'd0;
    assign cpu_hold   = (state_q != ST_DONE);
    assign done       = (state_q == ST_DONE);
    assign error      = (state_q == ST_ERROR);
    assign word_count = word_count_q;

endmodule
